// File: rtl/snes_joy_serializer.sv
// SNES controller-port emulator: parallel button vectors -> per-port serial JOY_DI streams.
// Optional autofire enabled by defining JOY_TURBO_EN (adds turbo_mask / turbo_rate ports).
module snes_joy_serializer #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned SHIFT_BITS = 16,
  parameter logic        FILL_BIT   = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS*SHIFT_BITS-1:0] buttons,
  input  logic                            joy_strb,
  input  logic [NUM_PORTS-1:0]            joy_clk,
`ifdef JOY_TURBO_EN
  input  logic [NUM_PORTS*SHIFT_BITS-1:0] turbo_mask,
  input  logic [3:0]                      turbo_rate,
`endif
  output logic [2*NUM_PORTS-1:0]          joy_di,
  output logic                            latch_pulse
);

  localparam int unsigned NB = NUM_PORTS * SHIFT_BITS;
  localparam int unsigned CW = $clog2(SHIFT_BITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SHIFT_BITS);

  logic [NB-1:0]        sync1;
  logic [NB-1:0]        sync2;
  logic [NB-1:0]        load_val;
  logic [NUM_PORTS-1:0] clk_last;
  logic [NUM_PORTS-1:0] edge_det;
  logic                 strb_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1       <= '0;
      sync2       <= '0;
      clk_last    <= '0;
      strb_last   <= 1'b0;
      latch_pulse <= 1'b0;
    end else begin
      sync1       <= buttons;
      sync2       <= sync1;
      clk_last    <= joy_clk;
      strb_last   <= joy_strb;
      latch_pulse <= strb_last & ~joy_strb;
    end
  end

  assign edge_det = joy_clk & ~clk_last;

`ifdef JOY_TURBO_EN
  logic [3:0] turbo_cnt;
  logic       turbo_phase;

  // Counter holding turbo_rate means this strobe is the (turbo_rate+1)th.
  always_ff @(posedge clk) begin
    if (reset) begin
      turbo_cnt   <= '0;
      turbo_phase <= 1'b0;
    end else if (joy_strb && !strb_last) begin
      if (turbo_cnt == turbo_rate) begin
        turbo_cnt   <= '0;
        turbo_phase <= ~turbo_phase;
      end else begin
        turbo_cnt <= turbo_cnt + 4'd1;
      end
    end
  end

  assign load_val = ~sync2 | (turbo_phase ? turbo_mask : '0);
`else
  assign load_val = ~sync2;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [SHIFT_BITS-1:0] sreg;
    logic [CW-1:0]         cnt;

    // Strobe has priority over a coincident clock edge.
    always_ff @(posedge clk) begin
      if (reset) begin
        sreg <= '1;
        cnt  <= '0;
      end else if (joy_strb) begin
        sreg <= load_val[p*SHIFT_BITS +: SHIFT_BITS];
        cnt  <= '0;
      end else if (edge_det[p] && (cnt != CNT_MAX)) begin
        sreg <= {FILL_BIT, sreg[SHIFT_BITS-1:1]};
        cnt  <= cnt + 1'b1;
      end
    end

    assign joy_di[2*p]   = sreg[0];
    assign joy_di[2*p+1] = 1'b1;
  end

endmodule

// File: tb/tb_snes_joy_serializer.sv
// Self-checking bench for snes_joy_serializer (2 ports x 16 bits, FILL_BIT = 0).
// Autofire scenario is built only when JOY_TURBO_EN is defined.
module tb_snes_joy_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] buttons;
  logic        joy_strb;
  logic [1:0]  joy_clk;
  logic [3:0]  joy_di;
  logic        latch_pulse;
`ifdef JOY_TURBO_EN
  logic [31:0] turbo_mask;
  logic [3:0]  turbo_rate;
`endif

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  snes_joy_serializer #(
    .NUM_PORTS (2),
    .SHIFT_BITS(16),
    .FILL_BIT  (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .joy_strb   (joy_strb),
    .joy_clk    (joy_clk),
`ifdef JOY_TURBO_EN
    .turbo_mask (turbo_mask),
    .turbo_rate (turbo_rate),
`endif
    .joy_di     (joy_di),
    .latch_pulse(latch_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clk(input int p);
    joy_clk[p] = 1'b1;
    tick();
    joy_clk[p] = 1'b0;
    tick();
  endtask

  task automatic do_strobe(input int cycles);
    joy_strb = 1'b1;
    repeat (cycles) tick();
    joy_strb = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_buttons(input logic [15:0] p0, input logic [15:0] p1);
    buttons = {p1, p0};
    repeat (3) tick();
  endtask

  // Data line after k clocks following a load of button vector btn.
  function automatic bit exp_bit(input logic [15:0] btn, input int k);
    return (k < 16) ? ~btn[k] : 1'b0;
  endfunction

  task automatic test_reset();
    bit e;
    reset = 1'b1; buttons = '0; joy_strb = 1'b0; joy_clk = '0;
    repeat (3) tick();
    total++;
    if (joy_di !== 4'b1111 || latch_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: joy_di=%b latch=%b want 1111/0", joy_di, latch_pulse);
    end
    reset = 1'b0;
    tick();
    for (int k = 1; k <= 20; k++) exp_q.push_back(exp_bit(16'h0000, k));
    for (int k = 1; k <= 20; k++) begin
      pulse_clk(0);
      e = exp_q.pop_front();
      total++;
      if (joy_di[0] !== e) begin
        bad++;
        $display("FAIL idle_edge%0d: data=%b want %b", k, joy_di[0], e);
      end
    end
    total++;
    if (joy_di[3:1] !== 3'b111) begin
      bad++;
      $display("FAIL idle_other_bits: joy_di[3:1]=%b want 111", joy_di[3:1]);
    end
  endtask

  task automatic test_latch();
    logic [15:0] seq;
    bit e;
    seq = 16'hFF7E;
    set_buttons(16'h0081, 16'h0000);
    for (int i = 0; i < 16; i++) exp_q.push_back(seq[i]);
    exp_q.push_back(1'b0);
    joy_strb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (latch_pulse !== 1'b0) begin
        bad++;
        $display("FAIL latch_early%0d: latch=%b want 0", i, latch_pulse);
      end
    end
    joy_strb = 1'b0;
    tick();
    total++;
    if (latch_pulse !== 1'b1) begin
      bad++;
      $display("FAIL latch_pulse: latch=%b want 1", latch_pulse);
    end
    tick();
    total++;
    if (latch_pulse !== 1'b0) begin
      bad++;
      $display("FAIL latch_width: latch=%b want 0", latch_pulse);
    end
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) pulse_clk(0);
      e = exp_q.pop_front();
      total++;
      if (joy_di[0] !== e || joy_di[1] !== 1'b1) begin
        bad++;
        $display("FAIL latch_seq%0d: di=%b want 1%b", k, joy_di[1:0], e);
      end
    end
    total++;
    if (joy_di[2] !== 1'b1) begin
      bad++;
      $display("FAIL latch_port1_idle: data=%b want 1", joy_di[2]);
    end
  endtask

  task automatic test_fill();
    bit e;
    do_strobe(3);
    for (int k = 1; k <= 20; k++) exp_q.push_back(exp_bit(16'h0081, k));
    for (int k = 1; k <= 20; k++) begin
      pulse_clk(0);
      e = exp_q.pop_front();
      total++;
      if (joy_di[0] !== e) begin
        bad++;
        $display("FAIL fill_edge%0d: data=%b want %b", k, joy_di[0], e);
      end
    end
    do_strobe(2);
    total++;
    if (joy_di[0] !== 1'b0) begin
      bad++;
      $display("FAIL reload_bit0: data=%b want 0", joy_di[0]);
    end
    pulse_clk(0);
    total++;
    if (joy_di[0] !== 1'b1) begin
      bad++;
      $display("FAIL reload_bit1: data=%b want 1", joy_di[0]);
    end
  endtask

  task automatic test_ports();
    bit e;
    set_buttons(16'h0081, 16'h0010);
    do_strobe(2);
    for (int k = 0; k <= 6; k++) exp_q.push_back(exp_bit(16'h0010, k));
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) pulse_clk(1);
      e = exp_q.pop_front();
      total++;
      if (joy_di[2] !== e || joy_di[0] !== 1'b0) begin
        bad++;
        $display("FAIL ports_edge%0d: p1=%b p0=%b want p1=%b p0=0", k, joy_di[2], joy_di[0], e);
      end
    end
    pulse_clk(0);
    total++;
    if (joy_di[0] !== 1'b1) begin
      bad++;
      $display("FAIL ports_p0_bit1: data=%b want 1", joy_di[0]);
    end
  endtask

  task automatic test_strobe_wins();
    bit e;
    set_buttons(16'h0081, 16'h0000);
    joy_strb = 1'b1;
    tick();
    tick();
    joy_clk[0] = 1'b1;
    tick();
    joy_strb = 1'b0;
    tick();
    joy_clk[0] = 1'b0;
    tick();
    for (int k = 0; k <= 7; k++) exp_q.push_back(exp_bit(16'h0081, k));
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) pulse_clk(0);
      e = exp_q.pop_front();
      total++;
      if (joy_di[0] !== e) begin
        bad++;
        $display("FAIL strobe_wins%0d: data=%b want %b", k, joy_di[0], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit e;
    do_strobe(2);
    repeat (3) pulse_clk(0);
    set_buttons(16'h0002, 16'h0000);
    do_strobe(2);
    for (int k = 0; k <= 16; k++) exp_q.push_back(exp_bit(16'h0002, k));
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) pulse_clk(0);
      e = exp_q.pop_front();
      total++;
      if (joy_di[0] !== e) begin
        bad++;
        $display("FAIL b2b_edge%0d: data=%b want %b", k, joy_di[0], e);
      end
    end
  endtask

  task automatic test_reset_abort();
    set_buttons(16'h0081, 16'h0010);
    do_strobe(2);
    pulse_clk(1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    total++;
    if (joy_di !== 4'b1111 || latch_pulse !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: joy_di=%b latch=%b want 1111/0", joy_di, latch_pulse);
    end
  endtask

`ifdef JOY_TURBO_EN
  task automatic test_turbo();
    int  tcnt;
    bit  phase;
    bit  e;
    turbo_mask = 32'h0000_0001;
    turbo_rate = 4'd1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tcnt = 0;
    phase = 1'b0;
    set_buttons(16'h0003, 16'h0003);
    for (int s = 0; s < 8; s++) begin
      if (tcnt == 1) begin
        tcnt = 0;
        phase = ~phase;
      end else begin
        tcnt++;
      end
      exp_q.push_back(phase);
      exp_q.push_back(1'b0);
      do_strobe(3);
      e = exp_q.pop_front();
      total++;
      if (joy_di[0] !== e || joy_di[2] !== 1'b0) begin
        bad++;
        $display("FAIL turbo_b%0d: p0=%b p1=%b want p0=%b p1=0", s, joy_di[0], joy_di[2], e);
      end
      pulse_clk(0);
      e = exp_q.pop_front();
      total++;
      if (joy_di[0] !== e) begin
        bad++;
        $display("FAIL turbo_y%0d: data=%b want %b", s, joy_di[0], e);
      end
    end
  endtask
`endif

  initial begin
`ifdef JOY_TURBO_EN
    turbo_mask = '0;
    turbo_rate = '0;
`endif
    test_reset();
    test_latch();
    test_fill();
    test_ports();
    test_strobe_wins();
    test_back_to_back();
    test_reset_abort();
`ifdef JOY_TURBO_EN
    test_turbo();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
